// File: rtl/gol_scan_out.sv
// ---------------------------------------------------------------------------
// gol_scan_out
//
// Turns the raster timing of a VGA-style display into cell reads from a
// double-buffered Game-of-Life frame memory. Each cell covers SCALE x SCALE
// screen pixels. The block walks the cell grid, presents the word address and
// the cell index within the word to the memory, and produces a colour index
// for the palette LUT. The index comes from the memory, a per-frame moving
// ramp, a solid colour or a checkerboard.
//
// Ports
//   clk_25       sole clock, all state updates on its rising edge
//   rst_n        asynchronous active-low reset
//   disp_active  visible-pixel strobe
//   line_end     one-cycle pulse at the end of each line
//   frame_end    one-cycle pulse at the end of each frame
//   mode         source select: 0 memory, 1 counter ramp, 2 solid, 3 checker
//   solid_color  colour used in mode 2
//   swap_req     one-cycle request to swap display banks at next frame end
//   swap_ack     one-cycle pulse after the swap has been executed
//   bank         memory bank currently being displayed
//   addr         memory word address of the current cell
//   pix_sel      cell index inside the addressed word
//   pixel_in     memory data, valid one cycle after addr/pix_sel
//   pixel_out    colour index to the LUT, two cycles after disp_active
//   pixel_valid  pixel_out qualifies a visible pixel
// ---------------------------------------------------------------------------
module gol_scan_out #(
   parameter int PIX_W    = 4,
   parameter int WORD_PIX = 8,
   parameter int ADDR_W   = 9,
   parameter int COLS     = 64,
   parameter int ROWS     = 48,
   parameter int SCALE    = 10,
   localparam int SEL_W   = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1
) (
   input  logic              clk_25,
   input  logic              rst_n,
   input  logic              disp_active,
   input  logic              line_end,
   input  logic              frame_end,
   input  logic [1:0]        mode,
   input  logic [PIX_W-1:0]  solid_color,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic              bank,
   output logic [ADDR_W-1:0] addr,
   output logic [SEL_W-1:0]  pix_sel,
   input  logic [PIX_W-1:0]  pixel_in,
   output logic [PIX_W-1:0]  pixel_out,
   output logic              pixel_valid
);

   localparam int SUB_W         = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int COL_W         = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W         = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int WORDS_PER_ROW = COLS / WORD_PIX;

   logic [SUB_W-1:0] sub_x;
   logic [SUB_W-1:0] sub_y;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;

   logic [1:0]       mode_r;
   logic [PIX_W-1:0] solid_r;
   logic [PIX_W-1:0] frame_cnt;
   logic             pending;

   logic             valid_d1;
   logic             mem_d1;
   logic [PIX_W-1:0] src_d1;
   logic [PIX_W-1:0] src_next;

   // Position counters. frame_end wins over everything so a frame always
   // starts at cell (0,0); line_end wins over disp_active. This ordering is
   // also what realigns the scan after a reset taken in the middle of a frame.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         sub_x <= '0;
         col   <= '0;
         sub_y <= '0;
         row   <= '0;
      end else if (frame_end) begin
         sub_x <= '0;
         col   <= '0;
         sub_y <= '0;
         row   <= '0;
      end else if (line_end) begin
         sub_x <= '0;
         col   <= '0;
         if (sub_y == SUB_W'(SCALE - 1)) begin
            sub_y <= '0;
            if (row == ROW_W'(ROWS - 1)) begin
               row <= '0;
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            sub_y <= sub_y + 1'b1;
         end
      end else if (disp_active) begin
         if (sub_x == SUB_W'(SCALE - 1)) begin
            sub_x <= '0;
            if (col == COL_W'(COLS - 1)) begin
               col <= '0;
            end else begin
               col <= col + 1'b1;
            end
         end else begin
            sub_x <= sub_x + 1'b1;
         end
      end
   end

   // The memory address comes straight from the counter registers, so the
   // memory sees it in the same cycle as the disp_active it belongs to.
   assign addr    = ADDR_W'(row) * ADDR_W'(WORDS_PER_ROW)
                  + ADDR_W'(col / COL_W'(WORD_PIX));
   assign pix_sel = SEL_W'(col % COL_W'(WORD_PIX));

   // Source settings and the ramp counter only move on frame_end, so a frame
   // is always drawn with a single consistent setting.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         mode_r    <= '0;
         solid_r   <= '0;
         frame_cnt <= '0;
      end else if (frame_end) begin
         mode_r    <= mode;
         solid_r   <= solid_color;
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // Bank swap handshake. Requests collect in pending until the next
   // frame_end; a request landing on that same edge is folded in directly.
   // Outside frame_end a request (including one in the ack cycle) just
   // arms pending for the following frame.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= 1'b0;
         bank     <= 1'b0;
         swap_ack <= 1'b0;
      end else if (frame_end) begin
         pending  <= 1'b0;
         swap_ack <= pending | swap_req;
         if (pending | swap_req) begin
            bank <= ~bank;
         end
      end else begin
         swap_ack <= 1'b0;
         if (swap_req) begin
            pending <= 1'b1;
         end
      end
   end

   // Colour for the generated modes, computed from the counters of the
   // disp_active cycle itself.
   always_comb begin
      src_next = '0;
      case (mode_r)
         2'd1:    src_next = frame_cnt + PIX_W'(col);
         2'd2:    src_next = solid_r;
         2'd3:    src_next = {PIX_W{col[0] ^ row[0]}};
         default: src_next = '0;
      endcase
   end

   // Two-stage output pipeline. Stage one waits for the memory (whose data
   // arrives one cycle after the address) and holds the generated colour
   // for the same cycle; stage two registers the chosen value. Every mode
   // therefore has the same two-cycle latency. The memory/generated choice
   // travels with the pixel so a mode change at frame_end cannot corrupt
   // pixels still in flight.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         valid_d1    <= 1'b0;
         mem_d1      <= 1'b0;
         src_d1      <= '0;
         pixel_valid <= 1'b0;
         pixel_out   <= '0;
      end else begin
         valid_d1    <= disp_active;
         mem_d1      <= (mode_r == 2'd0);
         src_d1      <= src_next;
         pixel_valid <= valid_d1;
         if (!valid_d1) begin
            pixel_out <= '0;
         end else if (mem_d1) begin
            pixel_out <= pixel_in;
         end else begin
            pixel_out <= src_d1;
         end
      end
   end

endmodule

// File: tb/tb_gol_scan_out.sv
// ---------------------------------------------------------------------------
// tb_gol_scan_out
//
// Directed bench for gol_scan_out with default parameters. Inputs change
// 1 ns after the rising edge and outputs are sampled at the same point,
// so every check sees settled register values.
// ---------------------------------------------------------------------------
module tb_gol_scan_out;

   logic       clk_25;
   logic       rst_n;
   logic       disp_active;
   logic       line_end;
   logic       frame_end;
   logic [1:0] mode;
   logic [3:0] solid_color;
   logic       swap_req;
   logic       swap_ack;
   logic       bank;
   logic [8:0] addr;
   logic [2:0] pix_sel;
   logic [3:0] pixel_in;
   logic [3:0] pixel_out;
   logic       pixel_valid;

   logic       clk_run;
   int         checks;
   int         errors;

   gol_scan_out dut (
      .clk_25      (clk_25),
      .rst_n       (rst_n),
      .disp_active (disp_active),
      .line_end    (line_end),
      .frame_end   (frame_end),
      .mode        (mode),
      .solid_color (solid_color),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .bank        (bank),
      .addr        (addr),
      .pix_sel     (pix_sel),
      .pixel_in    (pixel_in),
      .pixel_out   (pixel_out),
      .pixel_valid (pixel_valid)
   );

   // 25 MHz-ish clock that can be frozen for the asynchronous reset test.
   always begin
      #20;
      if (clk_run) clk_25 = ~clk_25;
   end

   function automatic logic [3:0] pat(int k);
      return 4'(k * 7 + 3);
   endfunction

   task automatic tick();
      @(posedge clk_25);
      #1;
   endtask

   task automatic applyStimulus(input logic de, input logic le, input logic fe, input logic sr);
      disp_active = de;
      line_end    = le;
      frame_end   = fe;
      swap_req    = sr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      clk_25      = 1'b0;
      clk_run     = 1'b1;
      rst_n       = 1'b0;
      mode        = 2'd0;
      solid_color = 4'h0;
      pixel_in    = 4'h0;
      checks      = 0;
      errors      = 0;
      applyStimulus(0, 0, 0, 0);

      // Reset state
      #10;
      checkOutput("rst_addr", addr, 0);
      checkOutput("rst_pix_sel", pix_sel, 0);
      checkOutput("rst_pixel_out", pixel_out, 0);
      checkOutput("rst_pixel_valid", pixel_valid, 0);
      checkOutput("rst_bank", bank, 0);
      checkOutput("rst_swap_ack", swap_ack, 0);
      #40;
      rst_n = 1'b1;
      tick();

      // Mode 0: 80 visible cycles along row 0
      $display("[TB] mode 0 scan");
      applyStimulus(0, 0, 1, 0);
      tick();
      for (int k = 0; k < 83; k++) begin
         applyStimulus(k < 80, 0, 0, 0);
         pixel_in = pat(k);
         if (k < 80) begin
            checkOutput("m0_addr", addr, 0);
            checkOutput("m0_pix_sel", pix_sel, k / 10);
         end
         if (k >= 2 && k < 82) begin
            checkOutput("m0_valid", pixel_valid, 1);
            checkOutput("m0_pixel", pixel_out, pat(k - 1));
         end else begin
            checkOutput("m0_valid_idle", pixel_valid, 0);
            checkOutput("m0_pixel_idle", pixel_out, 0);
         end
         tick();
      end

      // Line stepping and row wrap
      $display("[TB] line stepping");
      applyStimulus(0, 0, 1, 0);
      tick();
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 1, 0, 0);
         tick();
      end
      applyStimulus(1, 0, 0, 0);
      checkOutput("le10_addr", addr, 8);
      checkOutput("le10_pix_sel", pix_sel, 0);
      tick();
      for (int k = 0; k < 460; k++) begin
         applyStimulus(0, 1, 0, 0);
         tick();
      end
      applyStimulus(0, 0, 0, 0);
      checkOutput("le470_addr", addr, 376);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 1, 0, 0);
         tick();
      end
      applyStimulus(0, 0, 0, 0);
      checkOutput("le480_addr", addr, 0);
      tick();

      // Bank swap: coalesced requests, ack pulse, no request, ack-cycle request
      $display("[TB] bank swap");
      applyStimulus(0, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 1);
      checkOutput("sw_bank_pre", bank, 0);
      tick();
      applyStimulus(0, 0, 1, 0);
      checkOutput("sw_bank_hold", bank, 0);
      checkOutput("sw_ack_idle", swap_ack, 0);
      tick();
      applyStimulus(0, 0, 0, 0);
      checkOutput("sw_bank_1", bank, 1);
      checkOutput("sw_ack_1", swap_ack, 1);
      tick();
      applyStimulus(0, 0, 1, 0);
      checkOutput("sw_ack_once", swap_ack, 0);
      checkOutput("sw_bank_keep", bank, 1);
      tick();
      applyStimulus(0, 0, 1, 1);
      checkOutput("sw_norq_bank", bank, 1);
      checkOutput("sw_norq_ack", swap_ack, 0);
      tick();
      applyStimulus(0, 0, 0, 1);
      checkOutput("sw_same_bank", bank, 0);
      checkOutput("sw_same_ack", swap_ack, 1);
      tick();
      applyStimulus(0, 0, 0, 0);
      checkOutput("sw_ackrq_bank", bank, 0);
      tick();
      applyStimulus(0, 0, 1, 0);
      tick();
      applyStimulus(0, 0, 0, 0);
      checkOutput("sw_ackrq_swap", bank, 1);
      checkOutput("sw_ackrq_ack", swap_ack, 1);
      tick();

      // Mode change mid-frame is deferred to the next frame
      $display("[TB] deferred mode change");
      mode     = 2'd3;
      pixel_in = 4'h5;
      for (int k = 0; k < 14; k++) begin
         applyStimulus(k < 12, 0, 0, 0);
         if (k >= 2) checkOutput("mc_still_mem", pixel_out, 5);
         tick();
      end
      applyStimulus(0, 0, 1, 0);
      tick();
      for (int k = 0; k < 22; k++) begin
         applyStimulus(k < 20, 0, 0, 0);
         if (k == 2 || k == 11) checkOutput("mc_chk_col0", pixel_out, 4'h0);
         if (k == 12 || k == 21) checkOutput("mc_chk_col1", pixel_out, 4'hF);
         if (k == 12) checkOutput("mc_chk_valid", pixel_valid, 1);
         tick();
      end

      // Asynchronous reset mid-line with the clock frozen
      $display("[TB] async reset");
      for (int k = 0; k < 95; k++) begin
         applyStimulus(1, 0, 0, 0);
         tick();
      end
      applyStimulus(0, 0, 0, 0);
      checkOutput("ar_pre_addr", addr, 1);
      checkOutput("ar_pre_pixel", pixel_out, 4'hF);
      @(negedge clk_25);
      clk_run = 1'b0;
      #10;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_addr", addr, 0);
      checkOutput("ar_pix_sel", pix_sel, 0);
      checkOutput("ar_pixel_out", pixel_out, 0);
      checkOutput("ar_pixel_valid", pixel_valid, 0);
      checkOutput("ar_bank", bank, 0);
      checkOutput("ar_swap_ack", swap_ack, 0);
      #10;
      rst_n   = 1'b1;
      clk_run = 1'b1;
      tick();
      applyStimulus(1, 0, 0, 0);
      pixel_in = 4'h7;
      checkOutput("ar_first_addr", addr, 0);
      checkOutput("ar_first_sel", pix_sel, 0);
      checkOutput("ar_lat0_valid", pixel_valid, 0);
      tick();
      applyStimulus(0, 0, 0, 0);
      pixel_in = 4'h9;
      checkOutput("ar_lat1_valid", pixel_valid, 0);
      tick();
      checkOutput("ar_lat2_valid", pixel_valid, 1);
      checkOutput("ar_lat2_pixel", pixel_out, 4'h9);
      tick();
      checkOutput("ar_lat3_valid", pixel_valid, 0);
      checkOutput("ar_lat3_pixel", pixel_out, 0);

      // Mode 1 ramp and line_end colliding with frame_end
      $display("[TB] counter mode");
      mode = 2'd1;
      applyStimulus(0, 0, 1, 0);
      tick();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(k < 1, 0, 0, 0);
         if (k == 2) checkOutput("m1_fc1_col0", pixel_out, 4'h1);
         tick();
      end
      for (int k = 0; k < 15; k++) begin
         applyStimulus(0, 1, 0, 0);
         tick();
      end
      applyStimulus(0, 1, 1, 0);
      checkOutput("m1_pre_addr", addr, 8);
      tick();
      for (int k = 0; k < 9; k++) begin
         applyStimulus(0, 1, 0, 0);
         tick();
      end
      applyStimulus(0, 0, 0, 0);
      checkOutput("lf_sub_y_cleared", addr, 0);
      applyStimulus(0, 1, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0);
      checkOutput("lf_row_step", addr, 8);
      for (int k = 0; k < 13; k++) begin
         applyStimulus(k < 11, 0, 0, 0);
         if (k == 2) checkOutput("m1_fc2_col0", pixel_out, 4'h2);
         if (k == 12) checkOutput("m1_fc2_col1", pixel_out, 4'h3);
         tick();
      end

      // Mode 2 solid colour, sampled only at frame_end
      $display("[TB] solid mode");
      mode        = 2'd2;
      solid_color = 4'hA;
      applyStimulus(0, 0, 1, 0);
      tick();
      mode        = 2'd0;
      solid_color = 4'h3;
      pixel_in    = 4'h6;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(k < 1, 0, 0, 0);
         if (k == 2) checkOutput("m2_solid", pixel_out, 4'hA);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gol_scan_out.md
GOL_SCAN_OUT -- requirements
Module: gol_scan_out

Interface
REQ-001 The module SHALL have parameter PIX_W, default 4, giving bits per cell colour index.
REQ-002 The module SHALL have parameter WORD_PIX, default 8, giving cells per memory word; SEL_W = clog2(WORD_PIX).
REQ-003 The module SHALL have parameter ADDR_W, default 9, giving the memory word address width.
REQ-004 The module SHALL have parameter COLS, default 64, giving cells per row (multiple of WORD_PIX).
REQ-005 The module SHALL have parameter ROWS, default 48, giving cell rows per frame.
REQ-006 The module SHALL have parameter SCALE, default 10, giving screen pixels per cell in each axis.
REQ-007 The module SHALL have these ports:
- clk_25  in  1  sole clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- disp_active  in  1  visible-pixel strobe.
- line_end  in  1  one-cycle pulse at end of each line.
- frame_end  in  1  one-cycle pulse at end of each frame.
- mode  in  2  source select (0 memory, 1 counter, 2 solid, 3 checker).
- solid_color  in  PIX_W  colour for mode 2.
- swap_req  in  1  one-cycle bank swap request pulse.
- swap_ack  out  1  one-cycle pulse, swap executed.
- bank  out  1  memory bank being displayed.
- addr  out  ADDR_W  memory word address.
- pix_sel  out  SEL_W  cell index within the word.
- pixel_in  in  PIX_W  memory data, valid one cycle after addr/pix_sel.
- pixel_out  out  PIX_W  colour index to LUT.
- pixel_valid  out  1  pixel_out qualifies a visible pixel.

Function
REQ-008 Position counters sub_x (0..SCALE-1), col (0..COLS-1), sub_y (0..SCALE-1) and row (0..ROWS-1) SHALL be registered.
REQ-009 Each disp_active cycle SHALL increment sub_x; sub_x wrap SHALL increment col; col wraps COLS-1 -> 0.
REQ-010 line_end SHALL clear sub_x and col and increment sub_y; sub_y wrap SHALL increment row; row wraps ROWS-1 -> 0.
REQ-011 frame_end SHALL clear all four counters; frame_end SHALL take priority over line_end and disp_active in the same cycle.
REQ-012 addr SHALL equal row*(COLS/WORD_PIX) + col/WORD_PIX and pix_sel SHALL equal col mod WORD_PIX, both driven from the current counter registers.
REQ-013 pixel_out and pixel_valid SHALL appear exactly 2 cycles after the disp_active cycle they describe, in every mode.
REQ-014 pixel_valid SHALL be disp_active delayed 2 cycles; pixel_out SHALL be 0 whenever pixel_valid is 0.
REQ-015 mode and solid_color SHALL be sampled into internal registers only on frame_end; mid-frame changes SHALL have no effect until the next frame.
REQ-016 Mode 0 SHALL output pixel_in registered once.
REQ-017 Mode 1 SHALL output (frame_cnt + col) mod 2^PIX_W; frame_cnt is PIX_W bits, increments on each frame_end, wraps.
REQ-018 Mode 2 SHALL output the sampled solid_color.
REQ-019 Mode 3 SHALL output all-ones when col[0] XOR row[0] is 1, else 0.
REQ-020 swap_req SHALL set a pending flag; multiple requests before a frame_end SHALL coalesce into one swap.
REQ-021 On frame_end with pending set (or swap_req in the same cycle), bank SHALL toggle and pending clear on that edge, and swap_ack SHALL be 1 for exactly the following cycle.
REQ-022 swap_req arriving in the swap_ack cycle SHALL set pending for the next frame_end.
REQ-023 bank SHALL never change except at frame_end.

Reset
REQ-024 rst_n low SHALL immediately, without a clock, force the following to 0: counters, frame_cnt, pending, mode and solid registers, bank, swap_ack, addr, pix_sel, pixel_out, pixel_valid, and the delay pipeline.
REQ-025 After a mid-frame reset the module SHALL count from position 0 and realign at the first frame_end; no other recovery is required.

Verification
REQ-026 Reset, frame_end, then 80 disp_active cycles in mode 0 -> addr=0 throughout; pix_sel=0 for cycles 0-9, 1 for 10-19, ... 7 for 70-79; pixel_out(n+2) = pixel_in(n+1).
REQ-027 10 line_end pulses after frame_end, then disp_active -> addr=8, pix_sel=0; after 480 line_ends, row wraps -> addr=0.
REQ-028 Two swap_req pulses mid-frame -> bank stays 0; at frame_end bank=1; swap_ack high for exactly 1 cycle; then a further frame_end with no request -> bank stays 1.
REQ-029 mode changed 0->3 mid-frame -> output unchanged until frame_end; next frame gives pixel_out=0x0 at col 0 and 0xF at col 1 of row 0.
REQ-030 line_end and frame_end asserted in the same cycle -> row=0, sub_y=0 next cycle; mode 1 shows frame_cnt incremented by exactly 1.
REQ-031 rst_n dropped mid-line with clk_25 stopped -> all outputs 0 immediately; on release, first visible pixel has addr=0, pixel_valid 2 cycles after disp_active.
